// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_LANES  = 4;
  localparam int DMEM_WIDTH  = 32;
  localparam int DMEM_ADDR_W = DMEM_WIDTH - 2;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_t;

  // addr holds the word address (byte address >> 2); idx is its low bits
  typedef struct packed {
    dmem_op_t                op;
    logic [DMEM_ADDR_W-1:0]  addr;
    logic [DMEM_WIDTH-1:0]   wdata;
    logic [DMEM_LANES-1:0]   byte_en;
  } dmem_req_t;

  function automatic logic [DMEM_WIDTH-1:0] dmem_merge(
    input logic [DMEM_WIDTH-1:0] old_w,
    input logic [DMEM_WIDTH-1:0] new_w,
    input logic [DMEM_LANES-1:0] be
  );
    logic [DMEM_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < DMEM_LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-addressed array: synchronous per-lane write, combinational read.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic [AW-1:0]         wr_idx,
  input  logic [DMEM_LANES-1:0] wr_lane_en,
  input  logic [DMEM_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_idx,
  output logic [DMEM_WIDTH-1:0] rd_data
);

  logic [DMEM_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DMEM_LANES; i++) begin
      if (wr_lane_en[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with stall output.
// Optional one-entry posted write buffer enabled by DMEM_WBUF_EN.
//
// state | meaning
// IDLE  | waiting for a request; accepts it in its first cycle
// BUSY  | counting wait states; array access when the counter hits zero
// RESP  | one-cycle mem_resp (and mem_err) pulse
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WIDTH-1:0]      mem_address,
  input  logic [WIDTH-1:0]      mem_wdata,
  input  logic [DMEM_LANES-1:0] mem_byte_en,
  output logic [WIDTH-1:0]      mem_rdata,
  output logic                  mem_resp,
  output logic                  mem_err,
  output logic                  stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           state_q, state_d;
  dmem_req_t             req_q, req_d, new_req;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [AW-1:0]         arr_rd_idx, arr_wr_idx;
  logic [WIDTH-1:0]      arr_rd_data, arr_wr_data;
  logic [DMEM_LANES-1:0] arr_wr_en;

  logic [AW-1:0]         acc_idx;
  logic                  acc_oor;
  logic                  req_active;
  logic                  unused_addr_lsb;

  assign req_active      = mem_read | mem_write;
  assign unused_addr_lsb = ^mem_address[1:0];
  assign acc_idx         = req_q.addr[AW-1:0];
  assign acc_oor         = |req_q.addr[DMEM_ADDR_W-1:AW];

  always_comb begin
    new_req.op      = mem_write ? OP_WRITE : OP_READ;
    new_req.addr    = mem_address[WIDTH-1:2];
    new_req.wdata   = mem_wdata;
    new_req.byte_en = mem_byte_en;
  end

`ifdef DMEM_WBUF_EN
  logic                  wbuf_vld_q, wbuf_vld_d;
  logic [AW-1:0]         wbuf_idx_q, wbuf_idx_d;
  logic [WIDTH-1:0]      wbuf_data_q, wbuf_data_d;
  logic [DMEM_LANES-1:0] wbuf_be_q, wbuf_be_d;
  logic [DMEM_CNT_W-1:0] wbuf_cnt_q, wbuf_cnt_d;
  logic [AW-1:0]         new_idx;
  logic                  new_oor;
  logic                  wbuf_hit;

  assign new_idx     = mem_address[AW+1:2];
  assign new_oor     = |mem_address[WIDTH-1:AW+2];
  assign wbuf_hit    = wbuf_vld_q && (wbuf_idx_q == acc_idx);
  // The IDLE cycle reads the request's own word to build the posted-write response
  assign arr_rd_idx  = (state_q == IDLE) ? new_idx : acc_idx;
  assign arr_wr_idx  = wbuf_idx_q;
  assign arr_wr_data = wbuf_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbuf_vld_q  <= 1'b0;
      wbuf_idx_q  <= '0;
      wbuf_data_q <= '0;
      wbuf_be_q   <= '0;
      wbuf_cnt_q  <= '0;
    end else begin
      wbuf_vld_q  <= wbuf_vld_d;
      wbuf_idx_q  <= wbuf_idx_d;
      wbuf_data_q <= wbuf_data_d;
      wbuf_be_q   <= wbuf_be_d;
      wbuf_cnt_q  <= wbuf_cnt_d;
    end
  end
`else
  assign arr_rd_idx  = acc_idx;
  assign arr_wr_idx  = acc_idx;
  assign arr_wr_data = req_q.wdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    arr_wr_en = '0;
`ifdef DMEM_WBUF_EN
    wbuf_vld_d  = wbuf_vld_q;
    wbuf_idx_d  = wbuf_idx_q;
    wbuf_data_d = wbuf_data_q;
    wbuf_be_d   = wbuf_be_q;
    wbuf_cnt_d  = wbuf_cnt_q;

    // Background drain, independent of the request FSM
    if (wbuf_vld_q) begin
      if (wbuf_cnt_q != '0) begin
        wbuf_cnt_d = wbuf_cnt_q - 1'b1;
      end else begin
        arr_wr_en  = wbuf_be_q;
        wbuf_vld_d = 1'b0;
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (req_active) begin
`ifdef DMEM_WBUF_EN
          if (mem_write && !new_oor) begin
            // A full buffer holds the write off in IDLE until it drains
            if (!wbuf_vld_q) begin
              wbuf_vld_d  = 1'b1;
              wbuf_idx_d  = new_idx;
              wbuf_data_d = mem_wdata;
              wbuf_be_d   = mem_byte_en;
              wbuf_cnt_d  = CNT_INIT;
              rdata_d     = dmem_merge(arr_rd_data, mem_wdata, mem_byte_en);
              state_d     = RESP;
            end
          end else begin
            req_d   = new_req;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
`else
          req_d   = new_req;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          err_d   = acc_oor;
          if (acc_oor) begin
            rdata_d = '0;
          end else if (req_q.op == OP_WRITE) begin
`ifndef DMEM_WBUF_EN
            arr_wr_en = req_q.byte_en;
`endif
            rdata_d   = dmem_merge(arr_rd_data, req_q.wdata, req_q.byte_en);
          end else begin
`ifdef DMEM_WBUF_EN
            rdata_d = wbuf_hit ? dmem_merge(arr_rd_data, wbuf_data_q, wbuf_be_q)
                               : arr_rd_data;
`else
            rdata_d = arr_rd_data;
`endif
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk       (clk),
    .wr_idx    (arr_wr_idx),
    .wr_lane_en(arr_wr_en),
    .wr_data   (arr_wr_data),
    .rd_idx    (arr_rd_idx),
    .rd_data   (arr_rd_data)
  );

  assign mem_resp  = (state_q == RESP);
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;
  assign stall_o   = req_active & ~mem_resp;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WIDTH=32, DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_resp, mem_err, stall_o;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] r_data;
  logic        r_err;
  logic        r_got;
  int          r_n, r_stalls;

`ifdef DMEM_WBUF_EN
  localparam int WR_CYC = 2;
`else
  localparam int WR_CYC = 4;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .WIDTH      (32),
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_byte_en(mem_byte_en),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .mem_err    (mem_err),
    .stall_o    (stall_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; holds the request until mem_resp, then drops it at the next falling edge
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    mem_read    = rd;
    mem_write   = wr;
    mem_address = a;
    mem_wdata   = wd;
    mem_byte_en = be;
    r_n = 0; r_stalls = 0; r_got = 1'b0; r_data = '0; r_err = 1'b0;
    for (int i = 0; i < 40 && !r_got; i++) begin
      #1;
      r_n++;
      if (stall_o) r_stalls++;
      if (mem_resp) begin
        r_got  = 1'b1;
        r_data = mem_rdata;
        r_err  = mem_err;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("resp_seen", {31'b0, r_got}, 32'd1);
  endtask

  initial begin
    int extra;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_wdata = '0; mem_byte_en = '0;
    repeat (2) @(negedge clk);
    check("rst_resp",  {31'b0, mem_resp}, 32'd0);
    check("rst_err",   {31'b0, mem_err},  32'd0);
    check("rst_rdata", mem_rdata,         32'h0);
    check("rst_stall", {31'b0, stall_o},  32'd0);
    rst = 1'b1;
    @(negedge clk);

    xfer(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    check("wr10_cycles", r_n,    WR_CYC);
    check("wr10_rdata",  r_data, 32'hCAFEF00D);
    check("wr10_err",    {31'b0, r_err}, 32'd0);
    xfer(1'b0, 1'b1, 32'h40, 32'h0000_0000, 4'hF);
    xfer(1'b0, 1'b1, 32'h00, 32'h0BADF00D, 4'hF);

    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("rd10_cycles", r_n,      32'd4);
    check("rd10_stalls", r_stalls, 32'd3);
    check("rd10_rdata",  r_data,   32'hCAFEF00D);
    check("rd10_err",    {31'b0, r_err}, 32'd0);
    extra = 0;
    repeat (4) begin
      #1;
      if (mem_resp) extra++;
      @(negedge clk);
    end
    check("rd10_no_second_resp", extra, 32'd0);

    xfer(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
    xfer(1'b0, 1'b1, 32'h22, 32'h12340000, 4'hC);
    check("wr22_post_word", r_data, 32'h1234BEEF);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    check("rd20_merged", r_data, 32'h1234BEEF);

    xfer(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    check("oor_rd_err",   {31'b0, r_err}, 32'd1);
    check("oor_rd_rdata", r_data, 32'h0);
    xfer(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    check("oor_wr_err",   {31'b0, r_err}, 32'd1);
    check("oor_wr_rdata", r_data, 32'h0);
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check("oor_alias_untouched", r_data, 32'h0BADF00D);
    check("inrange_err",  {31'b0, r_err}, 32'd0);

    xfer(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF);
    check("rdwr30_err",   {31'b0, r_err}, 32'd0);
    check("rdwr30_rdata", r_data, 32'hA5A5A5A5);
    xfer(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    check("rd30_rdata",   r_data, 32'hA5A5A5A5);

    xfer(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    check("be0_wr_rdata", r_data, 32'hCAFEF00D);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("be0_rd_rdata", r_data, 32'hCAFEF00D);

    // Request dropped after acceptance still completes
    mem_read = 1'b1; mem_address = 32'h10;
    @(negedge clk);
    mem_read = 1'b0;
    r_got = 1'b0; r_data = '0;
    for (int i = 0; i < 20 && !r_got; i++) begin
      #1;
      if (mem_resp) begin
        r_got  = 1'b1;
        r_data = mem_rdata;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    check("drop_resp_seen", {31'b0, r_got}, 32'd1);
    check("drop_rdata",     r_data,         32'hCAFEF00D);

`ifndef DMEM_WBUF_EN
    // Reset in the BUSY cycle of a write abandons it
    mem_write = 1'b1; mem_address = 32'h40; mem_wdata = 32'hFFFFFFFF; mem_byte_en = 4'hF;
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    #1;
    check("midrst_resp",  {31'b0, mem_resp}, 32'd0);
    check("midrst_rdata", mem_rdata,         32'h0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (mem_resp) extra++;
    end
    check("midrst_no_resp", extra, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    check("midrst_rd40", r_data, 32'h0);
`else
    xfer(1'b0, 1'b1, 32'h50, 32'h11223344, 4'hF);
    check("wbuf_wr_cycles", r_n, 32'd2);
    xfer(1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
    check("wbuf_rd50", r_data, 32'h11223344);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage data port. It accepts read and write requests from the pipeline (address, wdata, byte enables) and returns mem_resp and rdata after a fixed wait-state count.
- Backed by an internal word-addressed SRAM array.
- Drives a stall to the hazard unit while a request is outstanding.

Parameters:
- WIDTH, 32, data/address width.
- DEPTH_WORDS, 1024, array depth in 32-bit words (power of 2).
- LATENCY, 2, cycles from request acceptance to mem_resp (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- mem_read  in  1  read request, held until mem_resp.
- mem_write  in  1  write request, held until mem_resp.
- mem_address  in  WIDTH  byte address; bits [1:0] are ignored for indexing.
- mem_wdata  in  WIDTH  write data, already lane-aligned by the requester.
- mem_byte_en  in  4  byte-lane enables, already shifted by address[1:0].
- mem_rdata  out  WIDTH  full read word, valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle pulse coincident with mem_resp for an out-of-range access.
- stall_o  out  1  request pending and not yet responded.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_resp=0, mem_err=0, mem_rdata=0, counter=0. Array contents are not reset. Reset mid-transaction abandons the access; a pending write is not committed.
- FSM states are IDLE, BUSY, RESP.
- IDLE:
  - If mem_read|mem_write: latch address, wdata, byte_en and op, then go to BUSY with cnt=LATENCY-1.
  - Acceptance occurs in the same cycle the request is first seen.
- BUSY:
  - While cnt!=0: decrement cnt.
  - At cnt==0: perform the array access and go to RESP.
- RESP:
  - mem_resp=1 for exactly one cycle, then return to IDLE.
  - The request is not re-accepted in the RESP cycle even if still asserted. The requester advances on mem_resp and must present its next request from the following cycle.
  - Back-to-back throughput is one access per LATENCY+2 cycles.
- stall_o = (mem_read|mem_write) & ~mem_resp. It is combinational and is 1 in the request's first cycle.
- Write: for each lane i with byte_en[i]=1, array[idx][8i+7:8i] = wdata[8i+7:8i]. Other lanes are unchanged. During the write response, mem_rdata is the post-write word.
- Read: mem_rdata = array[idx], the full word. Sign/zero extension and lane selection are done downstream in WB.
- idx = address[$clog2(DEPTH_WORDS)+1:2].
- Out of range (address[WIDTH-1:$clog2(DEPTH_WORDS)+2] != 0):
  - The write is dropped.
  - mem_rdata=0; mem_err=1 alongside mem_resp.
- mem_read & mem_write both 1: treated as a write. mem_err is not asserted.
- Request dropped by the requester while in BUSY: the latched request still completes. mem_resp still pulses.
- byte_en=0 with write: completes normally, array unchanged.

Optional Feature:
- Macro: DMEM_WBUF_EN.
- Defined: a one-entry posted write buffer is added.
  - A write is accepted from IDLE into the buffer if the buffer is empty. mem_resp is then asserted the next cycle (latency 1), and the buffer drains to the array LATENCY cycles later in the background.
  - A write while the buffer is full waits until it drains.
  - A read whose idx matches the buffered entry merges the buffered lanes into mem_rdata.
  - A read to a different idx proceeds in parallel with the drain.
  - Reset empties the buffer and discards its contents.
- Not defined: writes use the same LATENCY path as reads; no buffer logic is present.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum {IDLE, BUSY, RESP}.
  - Type for the latched request struct {op, idx, wdata, byte_en}.
  - Constant DMEM_LANES=4.
- Sub-module dmem_sram_array: synchronous word array with a per-lane write enable and a combinational read. The FSM owns all timing.

Test Plan:
- Reset, then read 0x0000_0010 with LATENCY=2 -> stall_o=1 for 3 cycles; mem_resp pulses in cycle 4 (counted from first request cycle); mem_rdata=initial word; no second pulse.
- Write 0x0000_0020 data 0xDEADBEEF, be=1111; then write 0x0000_0022 data 0x12340000, be=1100; then read 0x20 -> rdata=0x1234BEEF.
- Read 0x0000_1000 with DEPTH_WORDS=1024 -> mem_resp=1, mem_err=1, rdata=0; write to the same address leaves the array unchanged.
- mem_read=mem_write=1 at 0x30, wdata 0xA5A5A5A5, be=1111 -> treated as write; a subsequent read of 0x30 returns 0xA5A5A5A5.
- Assert rst in the BUSY cycle of a write to 0x40 (old value 0x0) -> mem_resp stays 0; after release, a read of 0x40 returns 0x0.
- DMEM_WBUF_EN defined: write 0x50=0x11223344, then immediate read 0x50 -> write resp after 1 cycle; read returns 0x11223344 before the drain completes.
